// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared constants, FSM states and width helper for the LCD SPI transmit queue
package lcd_spi_pkg;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_spi_tx_queue_sync_fifo.sv
// rtl/lcd_spi_tx_queue_sync_fifo.sv - synchronous FIFO with extra-bit pointers and registered flags
module sync_fifo
    import lcd_spi_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (level_d == PW'(DEPTH));
        empty_d  = (level_d == '0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/lcd_spi_tx_queue.sv
// rtl/lcd_spi_tx_queue.sv - queued {dc, data} SPI mode-0 writer for the LCD panel
module lcd_spi_tx_queue
    import lcd_spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int CS_BURST   = 1,
    parameter int CS_GAP     = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W:0]            wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [clog2(FIFO_DEPTH):0] level,
    output logic                       overflow,
    output logic                       busy,
    output logic                       word_done,
    output logic                       lcd_cs,
    output logic                       lcd_dc,
    output logic                       lcd_sclk,
    output logic                       lcd_mosi
);

    localparam int DIV_W = clog2(CLK_DIV + 1);
    localparam int BIT_W = clog2(DATA_W + 1);
    localparam int GAP_W = clog2(CS_GAP + 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] word_shl;
    logic [DATA_W:0]   fifo_dout;
    logic              cs_q, cs_d, dc_q, dc_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              done_q, done_d, busy_q, ovf_q, ovf_d;
    logic              pop, half_end;

    assign pop      = (state_q == LOAD);
    assign word_shl = word_q << 1;
    assign half_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign ovf_d    = ovf_q | (wr_en & full & ~pop);

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (wr_en),
        .pop       (pop),
        .din       (wr_data),
        .dout      (fifo_dout),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        word_d  = word_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (!empty) state_d = LOAD;
            end
            LOAD: begin
                {dc_d, word_d} = fifo_dout;
                mosi_d  = fifo_dout[DATA_W-1];
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                bit_d   = BIT_W'(DATA_W - 1);
                div_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (!half_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    // Falling transition: either advance to the next bit or close the word.
                    if (sclk_q) begin
                        if (bit_q == '0) begin
                            done_d = 1'b1;
                            if (CS_BURST != 0 && !empty) begin
                                state_d = LOAD;
                            end else begin
                                cs_d    = 1'b1;
                                gap_d   = '0;
                                state_d = GAP;
                            end
                        end else begin
                            bit_d  = bit_q - BIT_W'(1);
                            word_d = word_shl;
                            mosi_d = word_shl[DATA_W-1];
                        end
                    end
                end
            end
            GAP: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (gap_q == GAP_W'(CS_GAP - 1)) state_d = IDLE;
                else gap_d = gap_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            cs_q    <= 1'b1;
            dc_q    <= DC_CMD;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
            ovf_q   <= ovf_d;
        end
    end

    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign word_done = done_q;
    assign lcd_cs    = cs_q;
    assign lcd_dc    = dc_q;
    assign lcd_sclk  = sclk_q;
    assign lcd_mosi  = mosi_q;

endmodule

// File: tb/tb_lcd_spi_tx_queue.sv
// tb/tb_lcd_spi_tx_queue.sv - directed vector bench for lcd_spi_tx_queue (burst and non-burst instances)
module tb_lcd_spi_tx_queue;
    import lcd_spi_pkg::*;

    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          b_wr_en = 1'b0;
    logic [8:0]    b_wr_data = '0;
    logic          b_full, b_empty, b_overflow, b_busy, b_word_done;
    logic          b_cs, b_dc, b_sclk, b_mosi;
    logic [LW-1:0] b_level;

    logic          n_wr_en = 1'b0;
    logic [8:0]    n_wr_data = '0;
    logic          n_full, n_empty, n_overflow, n_busy, n_word_done;
    logic          n_cs, n_dc, n_sclk, n_mosi;
    logic [LW-1:0] n_level;

    lcd_spi_tx_queue u_burst (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .full(b_full), .empty(b_empty), .level(b_level), .overflow(b_overflow),
        .busy(b_busy), .word_done(b_word_done), .lcd_cs(b_cs), .lcd_dc(b_dc),
        .lcd_sclk(b_sclk), .lcd_mosi(b_mosi)
    );

    lcd_spi_tx_queue #(.CS_BURST(0), .CS_GAP(3)) u_nonburst (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_en(n_wr_en), .wr_data(n_wr_data),
        .full(n_full), .empty(n_empty), .level(n_level), .overflow(n_overflow),
        .busy(n_busy), .word_done(n_word_done), .lcd_cs(n_cs), .lcd_dc(n_dc),
        .lcd_sclk(n_sclk), .lcd_mosi(n_mosi)
    );

    typedef struct {
        logic [8:0] wdata;
        logic [7:0] exp_bits;
        logic       exp_dc;
    } vec_t;

    vec_t vecs [4];
    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word into an idle engine; times are counted from the cs falling edge.
    task automatic run_single(input vec_t v);
        int lat, nrise, last_rise, bad_space, wd_at, wd_cnt, cs_up, busy_dn, dc_bad;
        logic [7:0] bits;
        logic prev;
        b_wr_data = v.wdata;
        b_wr_en = 1'b1;
        tick();
        b_wr_en = 1'b0;
        lat = 0;
        while (b_cs && lat < 10) begin
            tick();
            lat++;
        end
        check("cs_latency", lat, 2);
        check("dc_at_load", b_dc, v.exp_dc);
        prev = b_sclk;
        bits = '0; nrise = 0; last_rise = -1; bad_space = 0;
        wd_at = -1; wd_cnt = 0; cs_up = -1; busy_dn = -1; dc_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (b_sclk && !prev) begin
                if (nrise < 8) bits[7-nrise] = b_mosi;
                if (last_rise >= 0 && k - last_rise != 4) bad_space++;
                last_rise = k;
                nrise++;
            end
            prev = b_sclk;
            if (b_word_done) begin
                wd_cnt++;
                if (wd_at < 0) wd_at = k;
            end
            if (b_cs && cs_up < 0) cs_up = k;
            if (!b_busy && busy_dn < 0) busy_dn = k;
            if (cs_up < 0 && b_dc !== v.exp_dc) dc_bad++;
        end
        check("sclk_rises", nrise, 8);
        check("sclk_spacing_errs", bad_space, 0);
        check("mosi_bits", bits, v.exp_bits);
        check("word_done_cycle", wd_at, 32);
        check("word_done_count", wd_cnt, 1);
        check("cs_rise_cycle", cs_up, 32);
        check("busy_drop_cycle", busy_dn, 34);
        check("dc_stable_errs", dc_bad, 0);
    endtask

    initial begin
        logic [8:0]  bw [4];
        logic [31:0] sbits;
        logic [7:0]  byte_sr;
        logic        prev_sclk, prev_cs, prev_dc;
        int cs_low, cs_falls, nrise, wd, dc_chg, dc_bad, t, sum, first_b, last_b;
        int fall_k [2];
        int high_between, sclk_bad, rises;

        vecs[0] = '{9'h02C, 8'b0010_1100, DC_CMD};
        vecs[1] = '{9'h1A5, 8'b1010_0101, DC_DATA};
        vecs[2] = '{9'h13C, 8'b0011_1100, DC_DATA};
        vecs[3] = '{9'h081, 8'b1000_0001, DC_CMD};

        // Reset state
        repeat (3) tick();
        check("rst_level", b_level, 0);
        check("rst_full", b_full, 0);
        check("rst_empty", b_empty, 1);
        check("rst_overflow", b_overflow, 0);
        check("rst_busy", b_busy, 0);
        check("rst_word_done", b_word_done, 0);
        check("rst_cs", b_cs, 1);
        check("rst_sclk", b_sclk, 0);
        check("rst_mosi", b_mosi, 0);
        check("rst_dc", b_dc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_single(vecs[i]);

        // Burst of four words: cs must stay low across all of them
        bw[0] = 9'h02A; bw[1] = 9'h100; bw[2] = 9'h100; bw[3] = 9'h1EF;
        prev_cs = b_cs; prev_sclk = b_sclk; prev_dc = b_dc;
        cs_low = 0; cs_falls = 0; nrise = 0; wd = 0; dc_chg = 0; dc_bad = 0; sbits = '0;
        for (int k = 0; k < 200; k++) begin
            b_wr_en = (k < 4);
            b_wr_data = bw[(k < 4) ? k : 0];
            tick();
            if (!b_cs) cs_low++;
            if (!b_cs && prev_cs) cs_falls++;
            if (b_sclk && !prev_sclk) begin
                sbits = {sbits[30:0], b_mosi};
                nrise++;
            end
            if (b_dc !== prev_dc) begin
                dc_chg++;
                if (b_sclk) dc_bad++;
            end
            if (b_word_done) wd++;
            prev_cs = b_cs; prev_sclk = b_sclk; prev_dc = b_dc;
        end
        b_wr_en = 1'b0;
        check("burst_cs_low_cycles", cs_low, 4 * 32 + 3);
        check("burst_cs_falls", cs_falls, 1);
        check("burst_rises", nrise, 32);
        check("burst_bits", sbits, 32'h2A00_00EF);
        check("burst_word_done", wd, 4);
        check("burst_dc_changes", dc_chg, 1);
        check("burst_dc_change_sclk_high", dc_bad, 0);

        // Non-burst instance: two words with CS_GAP=3
        prev_cs = n_cs; prev_sclk = n_sclk;
        cs_falls = 0; high_between = 0; sclk_bad = 0; wd = 0; nrise = 0; sbits = '0;
        fall_k[0] = -1; fall_k[1] = -1;
        for (int k = 0; k < 120; k++) begin
            n_wr_en = (k < 2);
            n_wr_data = (k == 0) ? 9'h055 : 9'h1C3;
            tick();
            if (!n_cs && prev_cs) begin
                if (cs_falls < 2) fall_k[cs_falls] = k;
                cs_falls++;
            end
            if (n_cs && cs_falls == 1) high_between++;
            if (n_cs && n_sclk) sclk_bad++;
            if (n_sclk && !prev_sclk) begin
                sbits = {sbits[30:0], n_mosi};
                nrise++;
            end
            if (n_word_done) wd++;
            prev_cs = n_cs; prev_sclk = n_sclk;
        end
        n_wr_en = 1'b0;
        check("nb_cs_falls", cs_falls, 2);
        check("nb_word_period", fall_k[1] - fall_k[0], 1 + 32 + 3 + 1);
        check("nb_cs_high_between", high_between, 5);
        check("nb_sclk_while_cs_high", sclk_bad, 0);
        check("nb_bits", sbits[15:0], 16'h55C3);
        check("nb_rises", nrise, 16);
        check("nb_word_done", wd, 2);
        check("nb_busy_after", n_busy, 0);

        // Fill to full while a word is shifting, push on the LOAD cycle, then overflow
        b_wr_data = 9'h1FF;
        b_wr_en = 1'b1;
        tick();
        b_wr_en = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            b_wr_data = 9'h110 + 9'(i);
            b_wr_en = 1'b1;
            tick();
        end
        b_wr_en = 1'b0;
        check("fill_level", b_level, 16);
        check("fill_full", b_full, 1);
        check("fill_overflow", b_overflow, 0);
        t = 0;
        while (!b_word_done && t < 40) begin
            tick();
            t++;
        end
        check("load_reached", (t < 40) ? 1 : 0, 1);
        b_wr_data = 9'h120;
        b_wr_en = 1'b1;
        tick();
        b_wr_en = 1'b0;
        check("pushpop_level", b_level, 16);
        check("pushpop_overflow", b_overflow, 0);
        check("pushpop_full", b_full, 1);
        b_wr_data = 9'h121;
        b_wr_en = 1'b1;
        tick();
        b_wr_en = 1'b0;
        check("ovf_set", b_overflow, 1);
        check("ovf_level", b_level, 16);
        wd = 0; sum = 0; first_b = -1; last_b = -1; byte_sr = '0; prev_sclk = b_sclk; t = 0;
        while (b_busy && t < 800) begin
            tick();
            t++;
            if (b_sclk && !prev_sclk) byte_sr = {byte_sr[6:0], b_mosi};
            prev_sclk = b_sclk;
            if (b_word_done) begin
                wd++;
                sum += int'(byte_sr);
                if (first_b < 0) first_b = int'(byte_sr);
                last_b = int'(byte_sr);
            end
        end
        check("drain_finished", (t < 800) ? 1 : 0, 1);
        check("drain_words", wd, 17);
        check("drain_first", first_b, 32'h10);
        check("drain_last", last_b, 32'h20);
        check("drain_sum", sum, 408);
        check("ovf_sticky", b_overflow, 1);
        check("drain_empty", b_empty, 1);

        // Reset in the middle of a word (bit 3 of 0xFF so mosi is high)
        b_wr_data = 9'h1FF;
        b_wr_en = 1'b1;
        tick();
        b_wr_data = 9'h012;
        tick();
        b_wr_en = 1'b0;
        rises = 0; prev_sclk = b_sclk; t = 0;
        while (rises < 5 && t < 60) begin
            tick();
            t++;
            if (b_sclk && !prev_sclk) rises++;
            prev_sclk = b_sclk;
        end
        check("bit3_reached", rises, 5);
        check("bit3_mosi", b_mosi, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs", b_cs, 1);
        check("mid_rst_sclk", b_sclk, 0);
        check("mid_rst_mosi", b_mosi, 0);
        check("mid_rst_level", b_level, 0);
        check("mid_rst_empty", b_empty, 1);
        check("mid_rst_busy", b_busy, 0);
        check("mid_rst_overflow", b_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sclk_bad = 0; cs_low = 0; t = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (b_sclk) sclk_bad++;
            if (!b_cs) cs_low++;
            if (b_busy) t++;
        end
        check("post_rst_sclk_edges", sclk_bad, 0);
        check("post_rst_cs_low", cs_low, 0);
        check("post_rst_busy", t, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
